scan_chain_ctrl: RTL and testbench

Parametrised scan-test chain with built-in sequencer. WIDTH scan flip-flops form a functional inverter chain (stage 0 loads D, stage i loads the inverse of stage i-1). An FSM runs a full scan test on a single start pulse: serial load via SI, one functional capture cycle, then serial unload on SO. It is the next-generation replacement for hand-wired fixed 8-stage scan chains in DFx test benches and designs.

---
 rtl/scan_chain_ctrl.sv | 117 +++++++++++
 tb/tb_scan_chain_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan chain of WIDTH inverter-linked stages with a built-in load/capture/unload sequencer.
// A single start pulse runs a full scan test; done pulses once after the last unload shift.
module scan_chain_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run_en,
    input  logic             D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             se,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        UNLOAD  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] chain_q, chain_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] func_next;
    logic [WIDTH-1:0] scan_next;
    logic             last_cnt;

    // Functional path is the inverter chain; scan path is a plain shift from SI toward SO.
    assign func_next = {~chain_q[WIDTH-2:0], D};
    assign scan_next = {chain_q[WIDTH-2:0], SI};
    assign last_cnt  = (cnt_q == LAST_CNT);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        chain_d = chain_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run_en) begin
                    chain_d = func_next;
                end
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                chain_d = scan_next;
                if (last_cnt) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CAPTURE: begin
                chain_d = func_next;
                state_d = UNLOAD;
                cnt_d   = '0;
            end

            UNLOAD: begin
                chain_d = scan_next;
                if (last_cnt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chain_q <= chain_d;
            done_q  <= done_d;
        end
    end

    assign Q        = chain_q;
    assign SO       = chain_q[WIDTH-1];
    assign se       = (state_q == SHIFT) || (state_q == UNLOAD);
    assign so_valid = (state_q == UNLOAD);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Randomised bench for scan_chain_ctrl at WIDTH=8 and WIDTH=3, with an SO scoreboard fed by
// a bit-level reference model of load, capture and unload.
module tb_scan_chain_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       run_en;
    logic       d_in;
    logic       si;

    logic [7:0] q8;
    logic       so8, se8, sov8, busy8, done8;
    logic [2:0] q3;
    logic       so3, se3, sov3, busy3, done3;

    logic [7:0] q_m;
    logic       so_m, se_m, sov_m, busy_m, done_m;

    int total;
    int bad;
    int cur_w;
    logic exp_so[$];

    scan_chain_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .run_en(run_en), .D(d_in), .SI(si),
        .Q(q8), .SO(so8), .se(se8), .so_valid(sov8), .busy(busy8), .done(done8)
    );

    scan_chain_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .run_en(run_en), .D(d_in), .SI(si),
        .Q(q3), .SO(so3), .se(se3), .so_valid(sov3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both instances see the same stimulus; only the one under test is observed.
    always_comb begin
        if (cur_w == 8) begin
            q_m = q8;  so_m = so8;  se_m = se8;  sov_m = sov8;  busy_m = busy8;  done_m = done8;
        end else begin
            q_m = {5'b0, q3};  so_m = so3;  se_m = se3;  sov_m = sov3;  busy_m = busy3;  done_m = done3;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (w=%0d t=%0t): got %0h expected %0h", name, cur_w, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial load: the k-th SI bit shifted in ends up in stage w-1-k.
    function automatic logic [7:0] load_model(input int w, input logic [7:0] s);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < w; k++) r[w-1-k] = s[k];
        return r;
    endfunction

    // One functional clock: stage 0 takes D, every later stage the inverse of its predecessor.
    function automatic logic [7:0] func_model(input int w, input logic [7:0] q, input logic d);
        logic [7:0] r;
        r = '0;
        r[0] = d;
        for (int i = 1; i < w; i++) r[i] = ~q[i-1];
        return r;
    endfunction

    function automatic logic spur(input int mode, input int cyc);
        if (mode == 2) return (cyc == 3) || (cyc == 10);
        if (mode == 1) return ($urandom_range(0, 3) == 0);
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!rst && sov_m) begin
            if (exp_so.size() == 0) check("so_unexpected", sov_m, 1'b0);
            else                    check("so_bit", so_m, exp_so.pop_front());
        end
    end

    task automatic do_reset(input int w);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start  = 1'($urandom);
            run_en = 1'($urandom);
            d_in   = 1'($urandom);
            si     = 1'($urandom);
            tick();
        end
        cur_w = w;
        exp_so.delete();
        rst    = 1'b0;
        start  = 1'b0;
        run_en = 1'b0;
        check("rst_q", q_m, 8'h00);
        check("rst_so", so_m, 1'b0);
        check("rst_busy", busy_m, 1'b0);
        check("rst_se", se_m, 1'b0);
        check("rst_valid", sov_m, 1'b0);
        check("rst_done", done_m, 1'b0);
    endtask

    // Entered in an IDLE cycle (possibly the done cycle of the previous test); returns in the done cycle.
    task automatic run_scan(input int w, input logic [7:0] s, input logic dcap, input logic [7:0] u,
                            input int smode, input int abort_at, output logic [7:0] fin);
        logic [7:0] l, c;
        l   = load_model(w, s);
        c   = func_model(w, l, dcap);
        fin = load_model(w, u);
        for (int j = 0; j < w; j++) exp_so.push_back(c[w-1-j]);

        start  = 1'b1;
        run_en = 1'($urandom);
        d_in   = 1'($urandom);
        si     = 1'($urandom);
        tick();

        for (int k = 0; k < w; k++) begin
            start  = spur(smode, k + 1);
            si     = s[k];
            run_en = 1'($urandom);
            d_in   = 1'($urandom);
            check("shift_se", se_m, 1'b1);
            check("shift_busy", busy_m, 1'b1);
            check("shift_valid", sov_m, 1'b0);
            check("shift_done", done_m, 1'b0);
            tick();
        end

        start  = spur(smode, w + 1);
        d_in   = dcap;
        si     = 1'($urandom);
        run_en = 1'($urandom);
        check("cap_se", se_m, 1'b0);
        check("cap_busy", busy_m, 1'b1);
        check("cap_entry_q", q_m, l);
        tick();
        check("unload_entry_q", q_m, c);

        for (int k = 0; k < w; k++) begin
            start  = spur(smode, w + 2 + k);
            si     = u[k];
            run_en = 1'($urandom);
            d_in   = 1'($urandom);
            check("unload_se", se_m, 1'b1);
            check("unload_valid", sov_m, 1'b1);
            check("unload_done", done_m, 1'b0);
            if (k == abort_at - 1) begin
                rst = 1'b1;
                tick();
                rst    = 1'b0;
                start  = 1'b0;
                run_en = 1'b0;
                exp_so.delete();
                check("abort_busy", busy_m, 1'b0);
                check("abort_q", q_m, 8'h00);
                check("abort_valid", sov_m, 1'b0);
                check("abort_se", se_m, 1'b0);
                for (int i = 0; i < 20; i++) begin
                    tick();
                    check("abort_no_done", done_m, 1'b0);
                end
                fin = 8'h00;
                return;
            end
            tick();
        end

        start  = 1'b0;
        run_en = 1'b0;
        check("done_pulse", done_m, 1'b1);
        check("done_busy", busy_m, 1'b0);
        check("done_se", se_m, 1'b0);
        check("final_q", q_m, fin);
    endtask

    task automatic idle_hold(input logic [7:0] q_exp, input int cycles);
        start  = 1'b0;
        run_en = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            d_in = 1'($urandom);
            si   = 1'($urandom);
            tick();
            check("idle_no_done", done_m, 1'b0);
            check("idle_hold_q", q_m, q_exp);
        end
    endtask

    task automatic func_test(input int w);
        logic [7:0] mq;
        logic [7:0] first;
        do_reset(w);
        d_in   = 1'b0;
        run_en = 1'b1;
        tick();
        first = (w == 8) ? 8'hFE : 8'h06;
        check("func_step1", q_m, first);
        tick();
        check("func_step2", q_m, 8'h02);
        run_en = 1'b0;
        d_in   = 1'b1;
        tick();
        tick();
        check("func_hold", q_m, 8'h02);
        mq = 8'h02;
        for (int i = 0; i < 16; i++) begin
            run_en = 1'($urandom);
            d_in   = 1'($urandom);
            if (run_en) mq = func_model(w, mq, d_in);
            tick();
            check("func_rand", q_m, mq);
        end
        run_en = 1'b0;
    endtask

    initial begin
        logic [7:0] fin;
        int w;
        total  = 0;
        bad    = 0;
        cur_w  = 8;
        rst    = 1'b1;
        start  = 1'b0;
        run_en = 1'b0;
        d_in   = 1'b0;
        si     = 1'b0;

        for (int wi = 0; wi < 2; wi++) begin
            w = (wi == 0) ? 8 : 3;
            do_reset(w);

            // SI = 1,0,1,1,0,0,1,0 then capture with D=1; stray starts at cycles 3 and 10 (w=8).
            run_scan(w, 8'h4D, 1'b1, 8'($urandom), (w == 8) ? 2 : 1, 0, fin);
            idle_hold(fin, 2);

            // Back-to-back: start presented in the done cycle.
            run_scan(w, 8'($urandom), 1'($urandom), 8'($urandom), 1, 0, fin);
            run_scan(w, 8'($urandom), 1'($urandom), 8'($urandom), 1, 0, fin);
            idle_hold(fin, 1);

            for (int t = 0; t < 12; t++) begin
                run_scan(w, 8'($urandom), 1'($urandom), 8'($urandom), 1, 0, fin);
                if ($urandom_range(0, 1) == 1) idle_hold(fin, $urandom_range(1, 3));
            end
            idle_hold(fin, 1);

            // Abort on the third unload cycle.
            run_scan(w, 8'($urandom), 1'($urandom), 8'($urandom), 1, 3, fin);

            func_test(w);
        end

        tick();
        check("so_leftover", exp_so.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
